// File: rtl/bf_cfg_loader.sv
// Double-buffered butterfly-network config loader: frames of per-stage beats fill a shadow
// bank that is swapped into the active bank on request. Define BF_CFG_SKEW_EN to skew stage k by k cycles.
module bf_cfg_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 9
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_in_valid,
    output logic                                   cfg_in_ready,
    input  logic [DATA_WIDTH/2-1:0]                cfg_in_data,
    input  logic                                   cfg_in_last,
    input  logic                                   swap_req,
    output logic [NUM_STAGES*(DATA_WIDTH/2)-1:0]   cfg_out,
    output logic                                   swap_done,
    output logic                                   frame_err,
    output logic [3:0]                             epoch,
    output logic [1:0]                             state_dbg
);

    localparam int SW     = DATA_WIDTH / 2;
    localparam int BANK_W = NUM_STAGES * SW;
    localparam int IDX_W  = $clog2(NUM_STAGES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [BANK_W-1:0]   shadow_q;
    logic [BANK_W-1:0]   active_q;
    logic                swap_done_q;
    logic                frame_err_q;
    logic [3:0]          epoch_q;

    logic accept;
    logic at_last;
    logic bad_beat;
    logic good_last;
    logic do_swap;

    // Handshake: a beat transfers on a rising edge where cfg_in_valid && cfg_in_ready;
    // ready depends only on state, never on valid, so it is stable within a cycle.
    assign cfg_in_ready = (state_q != FULL);
    assign accept       = cfg_in_valid && cfg_in_ready;
    assign at_last      = (idx_q == LAST_IDX);
    assign bad_beat     = accept && (cfg_in_last != at_last);
    assign good_last    = accept && cfg_in_last && at_last;
    assign do_swap      = (state_q == FULL) && swap_req;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bad_beat)       state_d = IDLE;
                else if (good_last) state_d = FULL;
                else if (accept)    state_d = LOAD;
            end
            LOAD: begin
                if (bad_beat)       state_d = IDLE;
                else if (good_last) state_d = FULL;
            end
            FULL: begin
                if (swap_req)       state_d = IDLE;
            end
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            swap_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            epoch_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            swap_done_q <= do_swap;
            frame_err_q <= bad_beat;
            if (do_swap) begin
                active_q <= shadow_q;
                epoch_q  <= epoch_q + 4'd1;
            end
            // A malformed frame throws away everything gathered so far.
            if (bad_beat) begin
                shadow_q <= '0;
                idx_q    <= '0;
            end else if (accept) begin
                shadow_q[idx_q*SW +: SW] <= cfg_in_data;
                idx_q <= good_last ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    assign swap_done = swap_done_q;
    assign frame_err = frame_err_q;
    assign epoch     = epoch_q;
    assign state_dbg = state_q;

`ifdef BF_CFG_SKEW_EN
    // Stage k sees the active bank k cycles late, tracking a wavefront through piped stages.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_direct
            assign cfg_out[0 +: SW] = active_q[0 +: SW];
        end else begin : g_delay
            logic [SW-1:0] sr_q [k];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) sr_q[j] <= '0;
                end else begin
                    sr_q[0] <= active_q[k*SW +: SW];
                    for (int j = 1; j < k; j++) sr_q[j] <= sr_q[j-1];
                end
            end
            assign cfg_out[k*SW +: SW] = sr_q[k-1];
        end
    end
`else
    assign cfg_out = active_q;
`endif

endmodule

// File: tb/tb_bf_cfg_loader.sv
// Directed bench for bf_cfg_loader: frame loading, malformed frames, swap timing,
// reset mid-frame and epoch wrap, with immediate assertions at every check point.
module tb_bf_cfg_loader;

    localparam int DW = 32;
    localparam int NS = 9;
    localparam int SW = DW / 2;
    localparam int OW = NS * SW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_in_valid;
    logic          cfg_in_ready;
    logic [SW-1:0] cfg_in_data;
    logic          cfg_in_last;
    logic          swap_req;
    logic [OW-1:0] cfg_out;
    logic          swap_done;
    logic          frame_err;
    logic [3:0]    epoch;
    logic [1:0]    state_dbg;

    int tests  = 0;
    int failed = 0;

    bf_cfg_loader #(.DATA_WIDTH(DW), .NUM_STAGES(NS)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_in_valid (cfg_in_valid),
        .cfg_in_ready (cfg_in_ready),
        .cfg_in_data  (cfg_in_data),
        .cfg_in_last  (cfg_in_last),
        .swap_req     (swap_req),
        .cfg_out      (cfg_out),
        .swap_done    (swap_done),
        .frame_err    (frame_err),
        .epoch        (epoch),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [SW-1:0] data, input logic last);
        cfg_in_valid = 1'b1;
        cfg_in_data  = data;
        cfg_in_last  = last;
        tick();
        cfg_in_valid = 1'b0;
        cfg_in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [SW-1:0] base);
        for (int k = 0; k < NS; k++) send_beat(base + SW'(k), k == NS - 1);
    endtask

    task automatic swap_pulse(input string tag);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check({tag, "_swap_done"}, swap_done, 1'b1);
    endtask

    // With skew, the deepest stage lands NS-1 cycles after the rest.
    task automatic settle();
`ifdef BF_CFG_SKEW_EN
        repeat (NS - 1) tick();
`endif
    endtask

    function automatic logic [OW-1:0] frame_vec(input logic [SW-1:0] base);
        logic [OW-1:0] v;
        v = '0;
        for (int k = 0; k < NS; k++) v[k*SW +: SW] = base + SW'(k);
        return v;
    endfunction

    initial begin
        logic [OW-1:0] exp1, exp2, exp3, exp4, exp6;
        logic [SW-1:0] old8, new8;
        exp1 = frame_vec(16'h0001);
        exp2 = frame_vec(16'h0100);
        exp3 = frame_vec(16'h0300);
        exp4 = frame_vec(16'h0400);
        exp6 = frame_vec(16'h0600);

        rst = 1'b1; cfg_in_valid = 1'b0; cfg_in_data = '0; cfg_in_last = 1'b0; swap_req = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_cfg_out", cfg_out, '0);
        check("rst_epoch", epoch, 4'd0);
        check("rst_swap_done", swap_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_ready", cfg_in_ready, 1'b1);

        // Basic frame 0x0001..0x0009 then swap.
        send_frame(16'h0001);
        check("t1_ready_full", cfg_in_ready, 1'b0);
        check("t1_cfg_before_swap", cfg_out, '0);
        swap_pulse("t1");
        check("t1_epoch", epoch, 4'd1);
        check("t1_ready_after", cfg_in_ready, 1'b1);
        settle();
        check("t1_cfg_out", cfg_out, exp1);
        tick();
        check("t1_swap_done_clear", swap_done, 1'b0);

        // Early last on beat 5.
        for (int k = 0; k < 5; k++) send_beat(16'h00A0 + SW'(k), k == 4);
        check("t2_frame_err", frame_err, 1'b1);
        check("t2_ready", cfg_in_ready, 1'b1);
        check("t2_active_kept", cfg_out, exp1);
        tick();
        check("t2_frame_err_clear", frame_err, 1'b0);
        // Missing last on beat 9.
        for (int k = 0; k < NS; k++) send_beat(16'h00B0 + SW'(k), 1'b0);
        check("t2_no_last_err", frame_err, 1'b1);
        check("t2_no_last_ready", cfg_in_ready, 1'b1);
        send_frame(16'h0100);
        check("t2_frame_ok", frame_err, 1'b0);
        swap_pulse("t2");
        settle();
        check("t2_cfg_out", cfg_out, exp2);
        check("t2_epoch", epoch, 4'd2);

        // FULL held for 20 cycles with valid pushing junk.
        send_frame(16'h0300);
        cfg_in_valid = 1'b1;
        cfg_in_data  = 16'hDEAD;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("t3_ready_low", cfg_in_ready, 1'b0);
            check("t3_cfg_hold", cfg_out, exp2);
        end
        cfg_in_valid = 1'b0;
        check("t3_no_swap_done", swap_done, 1'b0);
        swap_pulse("t3");
        settle();
        check("t3_cfg_out", cfg_out, exp3);
        check("t3_epoch", epoch, 4'd3);

        // swap_req coincident with the last beat is ignored.
        for (int k = 0; k < NS - 1; k++) send_beat(16'h0400 + SW'(k), 1'b0);
        swap_req = 1'b1;
        send_beat(16'h0400 + SW'(NS - 1), 1'b1);
        check("t4_no_swap_done", swap_done, 1'b0);
        check("t4_epoch_same", epoch, 4'd3);
        check("t4_ready_full", cfg_in_ready, 1'b0);
        tick();
        swap_req = 1'b0;
        check("t4_swap_done", swap_done, 1'b1);
        check("t4_epoch", epoch, 4'd4);
        settle();
        check("t4_cfg_out", cfg_out, exp4);

        // Reset after beat 4, with a beat and swap_req presented in the reset cycle.
        for (int k = 0; k < 4; k++) send_beat(16'h0500 + SW'(k), 1'b0);
        rst = 1'b1; cfg_in_valid = 1'b1; cfg_in_data = 16'hBEEF; swap_req = 1'b1;
        tick();
        rst = 1'b0; cfg_in_valid = 1'b0; swap_req = 1'b0;
        check("t5_cfg_out_zero", cfg_out, '0);
        check("t5_epoch_zero", epoch, 4'd0);
        check("t5_ready", cfg_in_ready, 1'b1);
        check("t5_swap_done", swap_done, 1'b0);
        send_frame(16'h0600);
        check("t5_frame_ok", frame_err, 1'b0);
        swap_pulse("t5");
        settle();
        check("t5_cfg_out", cfg_out, exp6);
        check("t5_epoch", epoch, 4'd1);

        // 17 swaps from reset; stage 8 latency measured on the last one.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 17; n++) begin
            send_frame(SW'(n << 8));
            if (n < 16) begin
                swap_pulse("t6");
                settle();
                if (n == 14) check("t6_epoch15", epoch, 4'd15);
                if (n == 15) check("t6_epoch_wrap", epoch, 4'd0);
            end
        end
        old8 = SW'((15 << 8) + 8);
        new8 = SW'((16 << 8) + 8);
        check("t6_stage8_old", cfg_out[8*SW +: SW], old8);
        swap_pulse("t6_last");
        check("t6_epoch17", epoch, 4'd1);
        check("t6_stage0_new", cfg_out[0 +: SW], SW'(16 << 8));
        for (int c = 1; c <= NS; c++) begin
            if (c > 1) tick();
`ifdef BF_CFG_SKEW_EN
            check("t6_stage8_skew", cfg_out[8*SW +: SW], (c < NS) ? old8 : new8);
`else
            check("t6_stage8_direct", cfg_out[8*SW +: SW], new8);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bf_cfg_loader.md
BF_CFG_LOADER -- requirements
Module: bf_cfg_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning network data width; each stage takes DATA_WIDTH/2 config bits.
REQ-002 SHALL have parameter NUM_STAGES, default 9, meaning the number of butterfly stages fed; legal range 1..16.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port cfg_in_valid, input, 1, config beat valid.
REQ-006 SHALL have port cfg_in_ready, output, 1, config beat accepted when valid and ready are both high.
REQ-007 SHALL have port cfg_in_data, input, DATA_WIDTH/2, config for one stage; beat n is for stage n.
REQ-008 SHALL have port cfg_in_last, input, 1, marks the final beat of a frame.
REQ-009 SHALL have port swap_req, input, 1, request to move the shadow bank into the active bank.
REQ-010 SHALL have port cfg_out, output, NUM_STAGES*DATA_WIDTH/2, per-stage config; stage k occupies bits [k*DATA_WIDTH/2 +: DATA_WIDTH/2].
REQ-011 SHALL have port swap_done, output, 1, one-cycle pulse when a swap is applied.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on a malformed frame.
REQ-013 SHALL have port epoch, output, 4, count of applied swaps, mod 16.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD and FULL, with a beat index idx of width ceil(log2(NUM_STAGES+1)).
REQ-015 SHALL drive cfg_in_ready high in IDLE and LOAD, and low in FULL.
REQ-016 SHALL on each accepted beat write cfg_in_data into shadow slot idx, then increment idx.
REQ-017 SHALL move IDLE->LOAD on an accepted beat without last.
REQ-018 SHALL move IDLE or LOAD->FULL on an accepted beat with last when idx==NUM_STAGES-1, and reset idx to 0.
REQ-019 SHALL, when the last flag is inconsistent with idx, pulse frame_err the next cycle, discard the shadow bank, set idx=0 and go to IDLE.
- Inconsistent means: last with idx!=NUM_STAGES-1, or no last with idx==NUM_STAGES-1.
REQ-020 SHALL, when NUM_STAGES==1, accept a single beat with last as a complete frame.
REQ-021 SHALL honour swap_req only in FULL.
- The shadow bank is copied to the active bank in that same edge.
- swap_done pulses and epoch increments (15 wraps to 0) in the following cycle.
- The FSM returns to IDLE.
REQ-022 SHALL ignore swap_req in IDLE or LOAD with no side effect, including in the cycle that accepts the last beat; that frame enters FULL and waits for a later swap_req.
REQ-023 SHALL hold FULL indefinitely until swap_req; the active bank is unchanged while loading.
REQ-024 SHALL allow the first beat of the next frame to be accepted in the cycle after a swap.

Reset
REQ-025 SHALL on rst set state=IDLE, idx=0, shadow=0, active=0, cfg_out=0 (straight pass), swap_done=0, frame_err=0, epoch=0.
REQ-026 SHALL drop a partial frame or a pending FULL frame when rst is asserted mid-operation.
REQ-027 SHALL give rst priority over a simultaneous swap_req or cfg beat.

Configuration
REQ-028 SHALL, with macro BF_CFG_SKEW_EN defined, drive stage k slice of cfg_out from the active bank delayed by k register cycles.
- Gives wavefront alignment with piped stages.
- After a swap, stage 0 changes 1 cycle after swap_req and stage k changes k+1 cycles after.
- Skew registers reset to 0.
REQ-029 SHALL, without BF_CFG_SKEW_EN, drive all cfg_out slices directly from the active bank; every stage changes 1 cycle after the swap edge.

Verification
REQ-030 SHALL pass: after rst, 9 beats 0x0001..0x0009 (last on beat 9) then swap_req -> swap_done=1 one cycle later, cfg_out stage k = k+1, epoch=1.
REQ-031 SHALL pass: last on beat 5 -> frame_err pulse, cfg_in_ready stays 1, active bank unchanged, next full frame loads normally.
REQ-032 SHALL pass: full frame, swap_req held low for 20 cycles -> cfg_in_ready=0 throughout and cfg_out unchanged; then swap_req -> swap.
REQ-033 SHALL pass: swap_req in same cycle as last beat -> no swap_done; second swap_req next cycle -> swap_done.
REQ-034 SHALL pass: rst asserted after beat 4 of 9 -> cfg_out=0, epoch=0; new full frame + swap works.
REQ-035 SHALL pass: 17 swaps -> epoch=1; with BF_CFG_SKEW_EN, stage 8 slice changes exactly 9 cycles after swap_req.
